ir_key_event: RTL

IR_KEY_EVENT -- requirements
Module: ir_key_event

---
 rtl/ir_pkg.sv | 22 ++
 rtl/ir_ms_tick.sv | 28 ++
 rtl/ir_key_event.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// Shared types and constants for the NEC IR key-event block.
package ir_pkg;

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} ir_state_t;

  localparam int unsigned ADDR_MSB  = 31;
  localparam int unsigned ADDR_LSB  = 24;
  localparam int unsigned NADDR_MSB = 23;
  localparam int unsigned NADDR_LSB = 16;
  localparam int unsigned CMD_MSB   = 15;
  localparam int unsigned CMD_LSB   = 8;
  localparam int unsigned NCMD_MSB  = 7;
  localparam int unsigned NCMD_LSB  = 0;

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

  function automatic logic frame_ok(input logic [31:0] d);
    return (d[NADDR_MSB:NADDR_LSB] == ~d[ADDR_MSB:ADDR_LSB]) &&
           (d[NCMD_MSB:NCMD_LSB]   == ~d[CMD_MSB:CMD_LSB]);
  endfunction

endpackage

// File: rtl/ir_ms_tick.sv
// Free-running prescaler: one-cycle tick every CLK_HZ/1000 clocks.
module ir_ms_tick #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int unsigned W   = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == W'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/ir_key_event.sv
// NEC key-event tracker: press / hold / release / error reporting.
// Optional autorepeat while held is enabled by defining IR_AUTOREPEAT_EN.
module ir_key_event
  import ir_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned RELEASE_MS = 110,
  parameter int unsigned HOLD_MS    = 500,
  parameter int unsigned RPT_MS     = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_vld,
  input  logic [31:0] frame_data,
  input  logic        repeat_vld,
  output logic        key_vld,
  output logic [7:0]  key_addr,
  output logic [7:0]  key_code,
  output logic        key_held,
  output logic        key_release,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  // One width for all ms timers, large enough for the biggest period.
  localparam int unsigned TMR_MAX0 = (RELEASE_MS > HOLD_MS) ? RELEASE_MS : HOLD_MS;
  localparam int unsigned TMR_MAX  = (TMR_MAX0 > RPT_MS) ? TMR_MAX0 : RPT_MS;
  localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);

  ir_state_t        state;
  logic [TMR_W-1:0] rel_ms;
  logic [TMR_W-1:0] hold_ms;
`ifdef IR_AUTOREPEAT_EN
  logic [TMR_W-1:0] rpt_ms;
`endif
  logic             tick;
  logic             good;
  logic             restart;
  logic             new_key;
  logic [7:0]       f_addr;
  logic [7:0]       f_cmd;

  ir_ms_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_comb begin
    f_addr  = frame_data[ADDR_MSB:ADDR_LSB];
    f_cmd   = frame_data[CMD_MSB:CMD_LSB];
    good    = frame_vld && frame_ok(frame_data);
    new_key = good && ((f_addr != key_addr) || (f_cmd != key_code));
    // A frame (even a bad one) masks a coincident repeat code.
    restart = good || (repeat_vld && !frame_vld);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      key_vld     <= 1'b0;
      key_release <= 1'b0;
      frame_err   <= 1'b0;
      key_held    <= 1'b0;
      key_addr    <= '0;
      key_code    <= '0;
      err_cnt     <= '0;
      rel_ms      <= '0;
      hold_ms     <= '0;
`ifdef IR_AUTOREPEAT_EN
      rpt_ms      <= '0;
`endif
    end else begin
      key_vld     <= 1'b0;
      key_release <= 1'b0;
      frame_err   <= 1'b0;

      if (frame_vld && !good) begin
        frame_err <= 1'b1;
        if (err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + 8'd1;
      end

      unique case (state)
        IDLE: begin
          if (good) begin
            state    <= PRESSED;
            key_vld  <= 1'b1;
            key_addr <= f_addr;
            key_code <= f_cmd;
            rel_ms   <= '0;
            hold_ms  <= '0;
          end
        end
        PRESSED, HELD: begin
          if (new_key) begin
            state       <= PRESSED;
            key_vld     <= 1'b1;
            key_release <= 1'b1;
            key_held    <= 1'b0;
            key_addr    <= f_addr;
            key_code    <= f_cmd;
            rel_ms      <= '0;
            hold_ms     <= '0;
          end else if (!restart && tick && rel_ms == TMR_W'(RELEASE_MS - 1)) begin
            state       <= IDLE;
            key_release <= 1'b1;
            key_held    <= 1'b0;
            rel_ms      <= '0;
            hold_ms     <= '0;
          end else begin
            if (restart)   rel_ms <= '0;
            else if (tick) rel_ms <= rel_ms + 1'b1;

            if (state == PRESSED && tick) begin
              if (hold_ms == TMR_W'(HOLD_MS - 1)) begin
                state    <= HELD;
                key_held <= 1'b1;
                hold_ms  <= '0;
`ifdef IR_AUTOREPEAT_EN
                key_vld  <= 1'b1;
                rpt_ms   <= '0;
`endif
              end else begin
                hold_ms <= hold_ms + 1'b1;
              end
            end
`ifdef IR_AUTOREPEAT_EN
            if (state == HELD && tick) begin
              if (rpt_ms == TMR_W'(RPT_MS - 1)) begin
                key_vld <= 1'b1;
                rpt_ms  <= '0;
              end else begin
                rpt_ms <= rpt_ms + 1'b1;
              end
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
